lsu_rmw: RTL and testbench

Load/store unit in the MEM stage, directly upstream of the 64-bit data memory (1024 x 64, async read, sync full-word write, word index = addr[12:3]). The memory only writes whole doublewords, so this block performs read-modify-write for SB/SH/SW. It also extracts and sign/zero-extends sub-word load results. It detects misaligned and illegal accesses and stalls the pipeline for one cycle per sub-word store.

---
 rtl/lsu_rmw.sv | 146 ++++++++++++++
 tb/tb_lsu_rmw.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - MEM-stage load/store unit with sub-word read-modify-write
module lsu_rmw #(
    parameter int XLEN      = 64,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [XLEN-1:0]      mem_rd,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wd,
    output logic                 mem_we,
    output logic [XLEN-1:0]      rdata,
    output logic                 stall,
    output logic                 misalign,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]           state_q;
    logic [XLEN-1:0]      merge_q;
    logic [XLEN-1:0]      addr_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic [1:0]      size;
    logic            active;
    logic            bad_f3;
    logic            bad_align;
    logic            ok;
    logic            do_load;
    logic            do_sd;
    logic            do_sub;
    logic [5:0]      sh;
    logic [XLEN-1:0] lane_rd;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] size_mask;
    logic [XLEN-1:0] merged;

    assign size   = funct3[1:0];
    // The request held during WRITE is the store already being committed, so it is not decoded again.
    assign active = req_valid && (state_q == IDLE);
    assign bad_f3 = is_store ? funct3[2] : (funct3 == 3'b111);

    always_comb begin
        case (size)
            2'd0:    bad_align = 1'b0;
            2'd1:    bad_align = addr[0];
            2'd2:    bad_align = |addr[1:0];
            default: bad_align = |addr[2:0];
        endcase
    end

    assign illegal  = active && bad_f3;
    assign misalign = active && !bad_f3 && bad_align;
    assign ok       = active && !bad_f3 && !bad_align;
    assign do_load  = ok && !is_store;
    assign do_sd    = ok && is_store && (size == 2'd3);
    assign do_sub   = ok && is_store && (size != 2'd3);

    assign sh      = {addr[2:0], 3'b000};
    assign lane_rd = mem_rd >> sh;

    always_comb begin
        case (size)
            2'd0: begin
                size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
                load_ext  = {{(XLEN-8){lane_rd[7] & ~funct3[2]}}, lane_rd[7:0]};
            end
            2'd1: begin
                size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
                load_ext  = {{(XLEN-16){lane_rd[15] & ~funct3[2]}}, lane_rd[15:0]};
            end
            2'd2: begin
                size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
                load_ext  = {{(XLEN-32){lane_rd[31] & ~funct3[2]}}, lane_rd[31:0]};
            end
            default: begin
                size_mask = {XLEN{1'b1}};
                load_ext  = mem_rd;
            end
        endcase
    end

    assign merged = (mem_rd & ~(size_mask << sh)) | ((wdata & size_mask) << sh);

    always_comb begin
        mem_addr = addr;
        mem_we   = 1'b0;
        mem_wd   = '0;
        rdata    = '0;
        stall    = 1'b0;
        if (state_q == WRITE) begin
            mem_addr = addr_q;
            mem_we   = 1'b1;
            mem_wd   = merge_q;
        end else begin
            if (do_load) begin
                rdata = load_ext;
            end
            if (do_sd) begin
                mem_we = 1'b1;
                mem_wd = wdata;
            end
            if (do_sub) begin
                stall = 1'b1;
            end
        end
        // Outputs are forced quiet while reset is held, even with a live request on the inputs.
        if (!rst_n) begin
            mem_we = 1'b0;
            mem_wd = '0;
            rdata  = '0;
            stall  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
            err_q   <= '0;
        end else begin
            if (state_q == WRITE) begin
                state_q <= IDLE;
            end else if (do_sub) begin
                state_q <= WRITE;
                merge_q <= merged;
                addr_q  <= addr;
            end
            if (misalign && (err_q != {ERR_CNT_W{1'b1}})) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - self-checking bench for lsu_rmw against a byte-level memory model
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem_rd;
    logic [63:0] mem_addr;
    logic [63:0] mem_wd;
    logic        mem_we;
    logic [63:0] rdata;
    logic        stall;
    logic        misalign;
    logic        illegal;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    lsu_rmw #(.XLEN(64), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .rdata(rdata),
        .stall(stall), .misalign(misalign), .illegal(illegal), .err_count(err_count)
    );

    // Data memory seen by the DUT: async read, sync full-word write, with a preload port.
    logic [63:0] mem [1024];
    logic        pl_we;
    logic [9:0]  pl_idx;
    logic [63:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr[12:3]] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr[12:3]];

    // Reference: a flat byte array covering the 8 KiB the memory index spans.
    logic [7:0] refb [8192];
    int nvec = 0;
    int nerr = 0;
    int err_exp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [63:0] a);
        logic [63:0] v = '0;
        int base = int'(a % 8192) / 8 * 8;
        for (int i = 0; i < 8; i++) v = v | (64'(refb[base + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a);
        int n = 1 << f3[1:0];
        int b = int'(a % 8192);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(refb[b + i]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        int n = 1 << f3[1:0];
        int b = int'(a % 8192);
        for (int i = 0; i < n; i++) refb[b + i] = 8'(d >> (8 * i));
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d);
        logic ill;
        logic mis;
        @(negedge clk);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = d;
        #1;
        ill = st ? f3[2] : (f3 == 3'b111);
        mis = !ill && ((a % (64'd1 << f3[1:0])) != 0);
        chk("illegal", 64'(illegal), 64'(ill));
        chk("misalign", 64'(misalign), 64'(mis));
        chk("mem_addr", mem_addr, a);
        if (ill || mis) begin
            chk("bad_we", 64'(mem_we), 64'd0);
            chk("bad_stall", 64'(stall), 64'd0);
            chk("bad_rdata", rdata, 64'd0);
            @(posedge clk);
            if (mis && err_exp < 65535) err_exp++;
            #1;
            chk("err_count", 64'(err_count), 64'(err_exp));
        end else if (!st) begin
            chk("ld_rdata", rdata, ref_load(f3, a));
            chk("ld_stall", 64'(stall), 64'd0);
            chk("ld_we", 64'(mem_we), 64'd0);
            @(posedge clk);
        end else if (f3 == 3'b011) begin
            chk("sd_we", 64'(mem_we), 64'd1);
            chk("sd_wd", mem_wd, d);
            chk("sd_stall", 64'(stall), 64'd0);
            ref_store(f3, a, d);
            @(posedge clk);
        end else begin
            chk("rmw1_stall", 64'(stall), 64'd1);
            chk("rmw1_we", 64'(mem_we), 64'd0);
            ref_store(f3, a, d);
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("rmw2_we", 64'(mem_we), 64'd1);
            chk("rmw2_stall", 64'(stall), 64'd0);
            chk("rmw2_addr", mem_addr, a);
            chk("rmw2_wd", mem_wd, ref_word(a));
            @(posedge clk);
        end
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] hi;
        rst_n = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b011; addr = 64'h100; wdata = '1;
        #1;
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wd", mem_wd, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);

        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            w = (i == 32) ? 64'h1122334455667788 : {$urandom, $urandom};
            pl_we = 1'b1; pl_idx = 10'(i); pl_data = w;
            for (int j = 0; j < 8; j++) refb[i * 8 + j] = 8'(w >> (8 * j));
        end
        @(negedge clk);
        pl_we = 1'b0; req_valid = 1'b0;
        rst_n = 1'b1;

        do_req(1'b0, 3'b000, 64'h100, 64'h0);
        chk("tp_lb", rdata, 64'hFFFFFFFFFFFFFF88);
        do_req(1'b0, 3'b100, 64'h107, 64'h0);
        do_req(1'b0, 3'b101, 64'h102, 64'h0);
        do_req(1'b0, 3'b010, 64'h104, 64'h0);
        do_req(1'b1, 3'b000, 64'h103, 64'hAB);
        #1;
        chk("tp_sb_word", mem[32], 64'h11223344AB667788);
        do_req(1'b0, 3'b011, 64'h100, 64'h0);
        do_req(1'b1, 3'b010, 64'h104, 64'hDEADBEEF);
        #1;
        chk("tp_sw_word", mem[32], 64'hDEADBEEFAB667788);
        do_req(1'b1, 3'b011, 64'h108, 64'hCAFE);
        do_req(1'b1, 3'b001, 64'h101, 64'h1234);
        do_req(1'b0, 3'b011, 64'h10C, 64'h0);
        chk("tp_err2", 64'(err_count), 64'd2);
        do_req(1'b1, 3'b100, 64'h100, 64'h55);
        chk("tp_err_ill", 64'(err_count), 64'd2);

        for (int k = 0; k < 300; k++) begin
            hi = {$urandom, $urandom} & ~64'h1FFF;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   hi | 64'(32'h100 + $urandom_range(0, 511)), {$urandom, $urandom});
        end

        // Reset while the merged word is pending must drop the write.
        w = ref_word(64'h100);
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 64'h100; wdata = 64'h5A;
        #1;
        chk("rw_stall", 64'(stall), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_we", 64'(mem_we), 64'd0);
        chk("rw_wd", mem_wd, 64'd0);
        chk("rw_stall0", 64'(stall), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0; addr = 64'h1F8;
        err_exp = 0;
        #1;
        chk("rw_idle_addr", mem_addr, 64'h1F8);
        chk("rw_idle_we", 64'(mem_we), 64'd0);
        chk("rw_err", 64'(err_count), 64'd0);
        chk("rw_word", mem[32], w);
        do_req(1'b0, 3'b011, 64'h100, 64'h0);

        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 64'h101;
        repeat (100) @(posedge clk);
        #1;
        chk("sat_mid", 64'(err_count), 64'd100);
        repeat (65536 - 100) @(posedge clk);
        #1;
        chk("sat_full", 64'(err_count), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold", 64'(err_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
